// File: rtl/eng_pc_seq_pkg.sv
// eng_pc_seq_pkg
// Shared types and default sizes for the microcode PC sequencer. The microcode
// ROM and the execute stage use the same defaults.
//   CTXT_N_DEF : number of hardware contexts (power of 2, >= 2)
//   PC_W_DEF   : microcode PC width, ROM depth is 2**PC_W_DEF
package eng_pc_seq_pkg;

   localparam int CTXT_N_DEF = 4;
   localparam int PC_W_DEF   = 8;
   localparam int CTXT_W_DEF = $clog2(CTXT_N_DEF);

   typedef logic [PC_W_DEF-1:0]   eng_pc_t;
   typedef logic [CTXT_W_DEF-1:0] eng_ctxt_t;

   typedef enum logic [1:0] {
      OP_NEXT = 2'd0,
      OP_JUMP = 2'd1,
      OP_WAIT = 2'd2,
      OP_DONE = 2'd3
   } eng_xa_op_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_READY    = 2'd1,
      ST_INFLIGHT = 2'd2,
      ST_WAIT     = 2'd3
   } eng_ctxt_st_t;

endpackage

// File: rtl/eng_pc_seq_if.sv
// eng_pc_seq_if
// Bus bundle between the PC sequencer and its neighbours.
//   start : i_start_vld/ctxt/pc in, o_start_rdy out (context launch)
//   fetch : o_fa_vld_r/ctxt_r/pc_r out, i_fa_stall in (issue to ROM)
//   exec  : i_xa_vld/ctxt/op/tgt_pc in (completion / redirect)
//   wake  : i_wake_vld/ctxt in
//   status: o_ctxt_busy_r, o_err_r out
// slave is the sequencer side, master is the surrounding pipeline side.
interface eng_pc_seq_if #(
   parameter int CTXT_N = eng_pc_seq_pkg::CTXT_N_DEF,
   parameter int PC_W   = eng_pc_seq_pkg::PC_W_DEF
);
   localparam int CTXT_W = $clog2(CTXT_N);

   logic              i_start_vld;
   logic [CTXT_W-1:0] i_start_ctxt;
   logic [PC_W-1:0]   i_start_pc;
   logic              o_start_rdy;
   logic              o_fa_vld_r;
   logic [CTXT_W-1:0] o_fa_ctxt_r;
   logic [PC_W-1:0]   o_fa_pc_r;
   logic              i_fa_stall;
   logic              i_xa_vld;
   logic [CTXT_W-1:0] i_xa_ctxt;
   logic [1:0]        i_xa_op;
   logic [PC_W-1:0]   i_xa_tgt_pc;
   logic              i_wake_vld;
   logic [CTXT_W-1:0] i_wake_ctxt;
   logic [CTXT_N-1:0] o_ctxt_busy_r;
   logic              o_err_r;

   modport slave (
      input  i_start_vld, i_start_ctxt, i_start_pc, i_fa_stall,
             i_xa_vld, i_xa_ctxt, i_xa_op, i_xa_tgt_pc, i_wake_vld, i_wake_ctxt,
      output o_start_rdy, o_fa_vld_r, o_fa_ctxt_r, o_fa_pc_r, o_ctxt_busy_r, o_err_r
   );

   modport master (
      output i_start_vld, i_start_ctxt, i_start_pc, i_fa_stall,
             i_xa_vld, i_xa_ctxt, i_xa_op, i_xa_tgt_pc, i_wake_vld, i_wake_ctxt,
      input  o_start_rdy, o_fa_vld_r, o_fa_ctxt_r, o_fa_pc_r, o_ctxt_busy_r, o_err_r
   );

endinterface

// File: rtl/eng_pc_seq_rr_arb.sv
// eng_rr_arb
// Combinational N-way round-robin arbiter. Grants the first set request bit
// at or after ptr, wrapping modulo N (N must be a power of 2).
//   req   : request vector
//   ptr   : highest-priority index
//   gnt   : one-hot grant
//   idx   : encoded grant index (0 when no grant)
//   found : any request granted
module eng_rr_arb
   import eng_pc_seq_pkg::*;
#(
   parameter int N = CTXT_N_DEF,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] gnt,
   output logic [W-1:0] idx,
   output logic         found
);

   logic [W-1:0] cand;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 0; k < N; k++) begin
         // W-bit add wraps naturally because N is a power of 2
         cand = ptr + W'(k);
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/eng_pc_seq.sv
// eng_pc_seq
// Microcode PC sequencer and context scheduler. Holds a PC and run state per
// context, issues one READY context per cycle round-robin to the fetch stage,
// and updates PC/state from execute-stage completions and wake events.
//   clk, arst_n : clock, async active-low reset
//   bus (slave) : start, fetch-issue, execute-completion, wake and status
//
// state       | meaning
// ------------+------------------------------------------------
// ST_IDLE     | context not running, may be started
// ST_READY    | waiting for an issue slot
// ST_INFLIGHT | one instruction issued, awaiting completion
// ST_WAIT     | parked until a wake event
module eng_pc_seq
   import eng_pc_seq_pkg::*;
#(
   parameter int CTXT_N = CTXT_N_DEF,
   parameter int PC_W   = PC_W_DEF
) (
   input  logic        clk,
   input  logic        arst_n,
   eng_pc_seq_if.slave bus
);

   localparam int CTXT_W = $clog2(CTXT_N);

   eng_ctxt_st_t      st_q [CTXT_N];
   eng_ctxt_st_t      st_d [CTXT_N];
   logic [PC_W-1:0]   pc_q [CTXT_N];
   logic [PC_W-1:0]   pc_d [CTXT_N];
   logic [CTXT_W-1:0] rr_q, rr_d;
   logic              fa_vld_q, fa_vld_d;
   logic [CTXT_W-1:0] fa_ctxt_q, fa_ctxt_d;
   logic [PC_W-1:0]   fa_pc_q, fa_pc_d;
   logic [CTXT_N-1:0] busy_q, busy_d;
   logic              err_q, err_d;
   logic [CTXT_N-1:0] req, gnt;
   logic [CTXT_W-1:0] gnt_idx;
   logic              gnt_found;
   logic              hold;
   logic              start_rdy;

   always_comb begin
      req = '0;
      for (int i = 0; i < CTXT_N; i++) req[i] = (st_q[i] == ST_READY);
   end

   eng_rr_arb #(.N(CTXT_N), .W(CTXT_W)) u_arb (
      .req   (req),
      .ptr   (rr_q),
      .gnt   (gnt),
      .idx   (gnt_idx),
      .found (gnt_found)
   );

   assign hold      = fa_vld_q && bus.i_fa_stall;
   assign start_rdy = (st_q[bus.i_start_ctxt] == ST_IDLE);

   always_comb begin
      st_d      = st_q;
      pc_d      = pc_q;
      rr_d      = rr_q;
      fa_vld_d  = fa_vld_q;
      fa_ctxt_d = fa_ctxt_q;
      fa_pc_d   = fa_pc_q;
      err_d     = err_q;
      busy_d    = '0;

      // Start, completion, wake and grant each need a different current state,
      // so on the same context at most one of them can take effect.
      if (bus.i_start_vld) begin
         if (start_rdy) begin
            st_d[bus.i_start_ctxt] = ST_READY;
            pc_d[bus.i_start_ctxt] = bus.i_start_pc;
         end else begin
            err_d = 1'b1;
         end
      end

      if (bus.i_xa_vld) begin
         if (st_q[bus.i_xa_ctxt] == ST_INFLIGHT) begin
            case (eng_xa_op_t'(bus.i_xa_op))
               OP_NEXT: begin
                  st_d[bus.i_xa_ctxt] = ST_READY;
                  pc_d[bus.i_xa_ctxt] = pc_q[bus.i_xa_ctxt] + PC_W'(1);
               end
               OP_JUMP: begin
                  st_d[bus.i_xa_ctxt] = ST_READY;
                  pc_d[bus.i_xa_ctxt] = bus.i_xa_tgt_pc;
               end
               OP_WAIT: begin
                  // a wake landing in the same cycle is not lost
                  st_d[bus.i_xa_ctxt] = (bus.i_wake_vld && bus.i_wake_ctxt == bus.i_xa_ctxt)
                                        ? ST_READY : ST_WAIT;
                  pc_d[bus.i_xa_ctxt] = pc_q[bus.i_xa_ctxt] + PC_W'(1);
               end
               default: st_d[bus.i_xa_ctxt] = ST_IDLE;
            endcase
         end else begin
            err_d = 1'b1;
         end
      end

      if (bus.i_wake_vld && st_q[bus.i_wake_ctxt] == ST_WAIT)
         st_d[bus.i_wake_ctxt] = ST_READY;

      if (!hold) begin
         fa_vld_d = gnt_found;
         if (gnt_found) begin
            for (int i = 0; i < CTXT_N; i++)
               if (gnt[i]) st_d[i] = ST_INFLIGHT;
            fa_ctxt_d = gnt_idx;
            fa_pc_d   = pc_q[gnt_idx];
            rr_d      = gnt_idx + CTXT_W'(1);
         end
      end

      for (int i = 0; i < CTXT_N; i++) busy_d[i] = (st_d[i] != ST_IDLE);
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < CTXT_N; i++) begin
            st_q[i] <= ST_IDLE;
            pc_q[i] <= '0;
         end
         rr_q      <= '0;
         fa_vld_q  <= 1'b0;
         fa_ctxt_q <= '0;
         fa_pc_q   <= '0;
         busy_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         st_q      <= st_d;
         pc_q      <= pc_d;
         rr_q      <= rr_d;
         fa_vld_q  <= fa_vld_d;
         fa_ctxt_q <= fa_ctxt_d;
         fa_pc_q   <= fa_pc_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
      end
   end

   assign bus.o_start_rdy   = start_rdy;
   assign bus.o_fa_vld_r    = fa_vld_q;
   assign bus.o_fa_ctxt_r   = fa_ctxt_q;
   assign bus.o_fa_pc_r     = fa_pc_q;
   assign bus.o_ctxt_busy_r = busy_q;
   assign bus.o_err_r       = err_q;

endmodule

// File: tb/tb_eng_pc_seq.sv
// tb_eng_pc_seq
// Directed bench for eng_pc_seq. Stimulus pushes the expected issue stream
// (context, PC) into a queue; a monitor pops and compares on every accepted
// fetch issue.
module tb_eng_pc_seq;
   import eng_pc_seq_pkg::*;

   localparam int CTXT_N = 4;
   localparam int PC_W   = 8;
   localparam int CTXT_W = 2;

   typedef struct {
      int ctxt;
      int pc;
   } exp_t;

   logic clk    = 1'b0;
   logic arst_n = 1'b0;
   int   tests  = 0;
   int   fails  = 0;
   exp_t sb[$];

   eng_pc_seq_if #(.CTXT_N(CTXT_N), .PC_W(PC_W)) bus ();

   eng_pc_seq #(.CTXT_N(CTXT_N), .PC_W(PC_W)) dut (
      .clk    (clk),
      .arst_n (arst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int c, input int pc);
      exp_t e;
      e.ctxt = c;
      e.pc   = pc;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_in();
      bus.i_start_vld  = 1'b0;
      bus.i_start_ctxt = '0;
      bus.i_start_pc   = '0;
      bus.i_fa_stall   = 1'b0;
      bus.i_xa_vld     = 1'b0;
      bus.i_xa_ctxt    = '0;
      bus.i_xa_op      = '0;
      bus.i_xa_tgt_pc  = '0;
      bus.i_wake_vld   = 1'b0;
      bus.i_wake_ctxt  = '0;
   endtask

   task automatic start(input int c, input int pc);
      bus.i_start_vld  = 1'b1;
      bus.i_start_ctxt = CTXT_W'(c);
      bus.i_start_pc   = PC_W'(pc);
   endtask

   task automatic xa(input int c, input eng_xa_op_t op, input int tgt);
      bus.i_xa_vld    = 1'b1;
      bus.i_xa_ctxt   = CTXT_W'(c);
      bus.i_xa_op     = op;
      bus.i_xa_tgt_pc = PC_W'(tgt);
   endtask

   task automatic wake(input int c);
      bus.i_wake_vld  = 1'b1;
      bus.i_wake_ctxt = CTXT_W'(c);
   endtask

   // Monitor: every issue accepted by fetch must match the next expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (arst_n && bus.o_fa_vld_r && !bus.i_fa_stall) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL issue_unexpected: got ctxt %0d pc 0x%0h, expected no issue at %0t",
                        bus.o_fa_ctxt_r, bus.o_fa_pc_r, $time);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("issue_ctxt", int'(bus.o_fa_ctxt_r), e.ctxt);
               chk("issue_pc", int'(bus.o_fa_pc_r), e.pc);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] pcs [4];
      int ncmp;
      pcs = '{8'hFF, 8'h20, 8'h30, 8'h40};

      // reset values
      idle_in();
      arst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_fa_vld", int'(bus.o_fa_vld_r), 0);
      chk("rst_fa_ctxt", int'(bus.o_fa_ctxt_r), 0);
      chk("rst_fa_pc", int'(bus.o_fa_pc_r), 0);
      chk("rst_busy", int'(bus.o_ctxt_busy_r), 0);
      chk("rst_err", int'(bus.o_err_r), 0);
      arst_n = 1'b1;
      step();

      // start ctxt 2 @0x10, then NEXT, JUMP 0x40, DONE
      start(2, 'h10);
      push(2, 'h10);
      step();
      idle_in();
      chk("t1_busy_after_start", int'(bus.o_ctxt_busy_r), 'b0100);
      chk("t1_vld_one_cycle", int'(bus.o_fa_vld_r), 0);
      step();
      chk("t1_vld_two_cycles", int'(bus.o_fa_vld_r), 1);
      bus.i_start_ctxt = 2'd2;
      #1;
      chk("t1_start_rdy_busy", int'(bus.o_start_rdy), 0);
      xa(2, OP_NEXT, 0);
      push(2, 'h11);
      step();
      idle_in();
      step();
      xa(2, OP_JUMP, 'h40);
      push(2, 'h40);
      step();
      idle_in();
      step();
      xa(2, OP_DONE, 0);
      step();
      idle_in();
      bus.i_start_ctxt = 2'd2;
      #1;
      chk("t2_start_rdy_done", int'(bus.o_start_rdy), 1);
      chk("t2_busy_done", int'(bus.o_ctxt_busy_r), 0);

      // four contexts back to back, continuous completions, 0xFF wraps to 0x00
      push(0, 'hFF); push(1, 'h20); push(2, 'h30); push(3, 'h40);
      push(0, 'h00); push(1, 'h21); push(2, 'h31); push(3, 'h41);
      ncmp = 0;
      for (int k = 0; k < 11; k++) begin
         idle_in();
         if (k < 4) start(k, int'(pcs[k]));
         if (k >= 2 && k <= 9) chk("t3_no_gap", int'(bus.o_fa_vld_r), 1);
         if (bus.o_fa_vld_r) begin
            xa(int'(bus.o_fa_ctxt_r), (ncmp < 4) ? OP_NEXT : OP_DONE, 0);
            ncmp++;
         end
         step();
      end
      idle_in();
      chk("t3_all_idle", int'(bus.o_ctxt_busy_r), 0);

      // stall for three cycles while other contexts become ready
      start(1, 'h50);
      push(1, 'h50);
      step();
      start(2, 'h60);
      push(2, 'h60);
      step();
      for (int k = 0; k < 4; k++) begin
         idle_in();
         chk("t4_hold_vld", int'(bus.o_fa_vld_r), 1);
         chk("t4_hold_ctxt", int'(bus.o_fa_ctxt_r), 1);
         chk("t4_hold_pc", int'(bus.o_fa_pc_r), 'h50);
         if (k < 3) begin
            bus.i_fa_stall = 1'b1;
            if (k == 0) begin start(3, 'h70); push(3, 'h70); end
            if (k == 1) begin start(0, 'h80); push(0, 'h80); end
            step();
         end
      end
      chk("t4_busy_all", int'(bus.o_ctxt_busy_r), 'b1111);
      for (int k = 0; k < 6; k++) begin
         idle_in();
         if (bus.o_fa_vld_r) xa(int'(bus.o_fa_ctxt_r), OP_DONE, 0);
         step();
      end
      idle_in();
      chk("t4_drained", int'(bus.o_ctxt_busy_r), 0);

      // WAIT on ctxt 1, parked until woken; then WAIT + wake in one cycle
      start(1, 'h30);
      push(1, 'h30);
      step();
      idle_in();
      step();
      xa(1, OP_WAIT, 0);
      step();
      for (int k = 0; k < 3; k++) begin
         idle_in();
         if (k == 0) wake(3);
         chk("t5_parked_vld", int'(bus.o_fa_vld_r), 0);
         chk("t5_parked_busy", int'(bus.o_ctxt_busy_r), 'b0010);
         step();
      end
      idle_in();
      wake(1);
      push(1, 'h31);
      step();
      idle_in();
      step();
      xa(1, OP_WAIT, 0);
      wake(1);
      push(1, 'h32);
      step();
      idle_in();
      chk("t5_same_cycle_gap", int'(bus.o_fa_vld_r), 0);
      step();
      chk("t5_same_cycle_reissue", int'(bus.o_fa_vld_r), 1);
      xa(1, OP_DONE, 0);
      step();
      idle_in();

      // protocol errors
      chk("t6_err_clear", int'(bus.o_err_r), 0);
      start(0, 'h00);
      push(0, 'h00);
      step();
      start(0, 'h05);
      step();
      idle_in();
      chk("t6_err_start_busy", int'(bus.o_err_r), 1);
      step();
      chk("t6_err_sticky", int'(bus.o_err_r), 1);
      arst_n = 1'b0;
      #1;
      chk("t6_rst_err", int'(bus.o_err_r), 0);
      chk("t6_rst_busy", int'(bus.o_ctxt_busy_r), 0);
      chk("t6_rst_vld", int'(bus.o_fa_vld_r), 0);
      step();
      arst_n = 1'b1;
      step();
      xa(3, OP_NEXT, 0);
      step();
      idle_in();
      chk("t6_err_xa_idle", int'(bus.o_err_r), 1);
      xa(0, OP_NEXT, 0);
      step();
      idle_in();
      step();
      chk("t6_err_still_set", int'(bus.o_err_r), 1);
      chk("t6_busy_after_bad_xa", int'(bus.o_ctxt_busy_r), 0);

      step();
      chk("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/eng_pc_seq.md
Name: eng_pc_seq

Overview:
Microcode PC sequencer and context scheduler for the engine pipeline. It holds a PC and a run state for each of CTXT_N contexts, and picks one ready context per cycle by round-robin. It drives the registered PC and context into the fetch stage (ROM lookup feeding the execute stage). It takes completion/redirect results back from the execute stage, which sets each context's next PC and state. Each context has at most one instruction in flight, so no intra-context hazard logic is needed.

Parameters:
CTXT_N, 4, number of hardware contexts (power of 2, >=2)
PC_W, 8, microcode PC width; ROM depth 2^PC_W
CTXT_W, $clog2(CTXT_N), derived context id width (localparam)

Ports:
clk  in  1  clock
arst_n  in  1  async active-low reset
i_start_vld  in  1  request to launch a context
i_start_ctxt  in  CTXT_W  context to launch
i_start_pc  in  PC_W  entry PC
o_start_rdy  out  1  combinational; target context is IDLE
o_fa_vld_r  out  1  issued instruction valid (registered)
o_fa_ctxt_r  out  CTXT_W  issued context
o_fa_pc_r  out  PC_W  issued PC, drives ROM address
i_fa_stall  in  1  fetch backpressure; hold issue
i_xa_vld  in  1  execute-stage completion valid
i_xa_ctxt  in  CTXT_W  completing context
i_xa_op  in  2  0=NEXT 1=JUMP 2=WAIT 3=DONE
i_xa_tgt_pc  in  PC_W  JUMP target
i_wake_vld  in  1  wake event
i_wake_ctxt  in  CTXT_W  context to wake
o_ctxt_busy_r  out  CTXT_N  per-context state != IDLE
o_err_r  out  1  sticky protocol error

Behaviour:
- Clocking/reset: one clock, clk. Reset is asynchronous, active-low, on arst_n.
- Reset values: all contexts IDLE; all PCs 0; RR pointer 0. o_fa_vld_r, o_fa_ctxt_r, o_fa_pc_r, o_ctxt_busy_r and o_err_r are all 0.
- Reset mid-operation discards in-flight state. Completions arriving after reset count as errors.
- Per-context FSM states: IDLE, READY, INFLIGHT, WAIT.
- Start: fires when i_start_vld && o_start_rdy. IDLE->READY; pc<=i_start_pc.
  - i_start_vld to a non-IDLE context is ignored and sets o_err_r.
- Issue:
  - Issue occurs when no output is held (i.e. !(o_fa_vld_r && i_fa_stall)) and at least one context is READY.
  - The round-robin arbiter grants the first READY context starting at rr_ptr.
  - Next cycle: o_fa_vld_r=1, o_fa_ctxt_r=grant, o_fa_pc_r=pc[grant]. The granted context goes READY->INFLIGHT, and rr_ptr <= grant+1 (mod CTXT_N).
  - If no output is held and no context is READY, o_fa_vld_r<=0.
- Stall: while o_fa_vld_r && i_fa_stall, all o_fa_* hold, there is no grant, and rr_ptr holds.
- Latency:
  - Start at cycle t -> READY at t+1 -> o_fa_vld_r at t+2 (if it wins arbitration and there is no stall).
  - Completion at t -> READY at t+1 -> reissue visible at t+2.
- Completion (i_xa_vld), only legal for an INFLIGHT context:
  - NEXT: pc<=pc+1, READY.
  - JUMP: pc<=i_xa_tgt_pc, READY.
  - WAIT: pc<=pc+1, WAIT.
  - DONE: IDLE.
  - Completion for a non-INFLIGHT context is ignored and sets o_err_r.
- PC arithmetic: modulo 2^PC_W. pc 2^PC_W-1 + NEXT -> 0 (no error).
- Wake: a WAIT context goes WAIT->READY. A wake to any other state is ignored (no error, not remembered).
  - Same-cycle WAIT completion and wake for the same context: the context ends READY (wake wins).
- Simultaneous events on different contexts (start, completion, wake, grant) all apply in the same cycle.
  - Start targeting the context completing DONE in that cycle is not accepted, because o_start_rdy uses the current state.
- o_ctxt_busy_r reflects the registered FSM state.
- o_err_r clears only on reset.

Decomposition:
- q_pkg gains:
  - eng_pc_t (logic [PC_W-1:0])
  - eng_ctxt_t
  - enum eng_xa_op_t {NEXT, JUMP, WAIT, DONE}
  - enum eng_ctxt_st_t {IDLE, READY, INFLIGHT, WAIT}
- PC_W and CTXT_N defaults belong in cfg_pkg so that the ROM and the execute stage share them.
- One sub-module: eng_rr_arb. It is a parameterised N-way round-robin arbiter taking a request vector and a pointer, and returning a one-hot grant and an encoded index. It is combinational.

Test Plan:
- Reset, then start ctxt 2 at pc 0x10 at t0 -> o_fa_vld_r=1, ctxt=2, pc=0x10 at t0+2; o_ctxt_busy_r=4'b0100 at t0+1.
- Ctxt 2 completions NEXT, then JUMP 0x40, then DONE -> issues pc 0x11, then 0x40, then ctxt 2 goes IDLE and o_start_rdy=1 for ctxt 2.
- Contexts 0-3 all READY with continuous NEXT completions -> issue order 0,1,2,3,0 … with no gaps; PC 0xFF + NEXT -> 0x00.
- i_fa_stall held 3 cycles with o_fa_vld_r=1 -> o_fa_* held constant; no context changes to INFLIGHT; after release the next grant follows the RR order.
- WAIT on ctxt 1 -> no issue for ctxt 1 until i_wake_vld for ctxt 1; wake in the same cycle as the WAIT completion -> ctxt 1 READY and reissued 2 cycles later.
- Error cases each set o_err_r=1, which stays set until arst_n is asserted:
  - start to busy ctxt 0;
  - i_xa_vld for IDLE ctxt 3.
